cache_fsm: RTL and testbench
============================

# cache_fsm

Sequencing controller for one cache set array. It decodes processor read/write requests against the set's hit/dirty/tag feedback and drives the set's 5-bit control vector. On a miss it runs a word-serial write-back of a dirty victim line, then a word-serial refill from memory. It stalls the processor until the access hits.

## Interface
- TAG_WIDTH, default `CACHE_T: tag bits; TAG_WIDTH + SET_WIDTH + OFFSET_WIDTH = 32
- SET_WIDTH, default `CACHE_S: set-index bits
- OFFSET_WIDTH, default `CACHE_B: byte-offset bits; words per line W = 2^(OFFSET_WIDTH-2), W ≥ 2
- clk_i  in  1  clock (only clock)
- rst_i  in  1  synchronous active-high reset
- read_en_i  in  1  processor read request
- write_en_i  in  1  processor write request
- addr_i  in  32  processor address; held stable while stall_o=1
- hit_i  in  1  set hit (tag match on a valid line)
- dirty_i  in  1  victim line dirty
- tag_i  in  TAG_WIDTH  victim line tag
- mem_ready_i  in  1  memory accepted/returned current word this cycle
- control_o  out  5  {write_en, set_valid, set_dirty, strategy_en, offset_sel} to set
- mem_addr_o  out  32  memory word address; its word-offset bits also index the set
- mem_read_en_o  out  1  memory read request (refill)
- mem_write_en_o  out  1  memory write request (write-back; data = set read_data_o)
- stall_o  out  1  processor must hold request

## Operation
- States: IDLE, WRITE_BACK, ALLOCATE. Word counter cnt, width OFFSET_WIDTH-2.
- req = read_en_i | write_en_i. A request with both enables set is treated as a write.
- IDLE, no req: control_o=0, mem enables 0, stall_o=0.
- IDLE, req & hit_i: stall_o=0, strategy_en=1, offset_sel=1.
  - Write also drives write_en=1, set_valid=1, set_dirty=1.
  - Read drives write_en=0.
  - State stays IDLE.
- IDLE, req & ~hit_i: stall_o=1, control_o=0.
  - Next state WRITE_BACK if dirty_i, else ALLOCATE.
  - cnt←0.
- WRITE_BACK:
  - mem_write_en_o=1.
  - mem_addr_o = {tag_i, addr_i[SET_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH], cnt, 2'b00}.
  - control_o=0, so offset_sel=0 and the set reads the word at mem_addr_o.
  - On mem_ready_i: cnt←cnt+1.
  - On mem_ready_i with cnt==W-1: cnt←0, go to ALLOCATE.
- ALLOCATE:
  - mem_read_en_o=1.
  - mem_addr_o = {addr_i[31:OFFSET_WIDTH], cnt, 2'b00}.
  - On mem_ready_i: control_o = {1,1,0,0,0}, which writes the word into the victim line with valid set and dirty cleared. cnt←cnt+1.
  - On mem_ready_i with cnt==W-1: go to IDLE. The request is then re-evaluated and hits.
- Without mem_ready_i, a state holds with mem_addr_o and the enable stable. cnt wraps only via the transitions above.
- strategy_en is asserted only on an IDLE hit. Refill writes never update replacement state.
- stall_o=1 in WRITE_BACK and ALLOCATE regardless of req.
- mem_addr_o=0 in IDLE.
- If req drops mid-miss (illegal), the sequence still completes.

## Timing
- Reset: state=IDLE, cnt=0.
- Outputs after reset with no req: control_o=0, mem_addr_o=0, mem_read_en_o=0, mem_write_en_o=0, stall_o=0.
- Reset mid-miss: on the next edge, abort to IDLE and drop mem enables. Set contents are left as-is; a partial refill leaves set_valid already written, and the processor retries.
- State and cnt are registers. All outputs are combinational from state, cnt and inputs. mem_ready_i may arrive in the same cycle as the request.
- Hit latency: 0 stall cycles.
- Clean miss with 1-cycle memory (mem_ready_i always 1): 1 IDLE miss cycle + W ALLOCATE cycles + 1 IDLE hit cycle.
- Dirty miss: the clean-miss count plus W WRITE_BACK cycles.
- Each memory wait cycle adds exactly 1 cycle per word.

## Test plan
OFFSET_WIDTH=4 (W=4), SET_WIDTH=2.
- Reset then idle: all outputs 0. Read hit at 0x0000_1008 with hit_i=1 → same cycle stall_o=0, control_o=5'b00011, no memory enables.
- Write hit: write_en_i=1, hit_i=1 → control_o=5'b11111 for one cycle, stall_o=0.
- Clean read miss at 0x0000_1234, mem_ready_i=1 → ALLOCATE addresses 0x1230, 0x1234, 0x1238, 0x123C. control_o=5'b11000 on each. Hit on the 6th cycle with control_o=5'b00011.
- Dirty write miss at 0x0000_0010, tag_i=victim tag 0xABC (set index 1) → WRITE_BACK words at {0xABC, 2'b01, cnt, 00}, then refill 0x10–0x1C, then write-hit control_o=5'b11111.
- Memory wait: mem_ready_i low for 3 cycles on word 2 → mem_addr_o and mem_read_en_o held stable. No set write and no cnt change until mem_ready_i rises.
- rst_i during ALLOCATE cnt=2 → next cycle state IDLE, mem_read_en_o=0, stall_o follows the IDLE hit/miss rule.

Source files
------------

// File: rtl/cache_fsm.sv
// ---------------------------------------------------------------------------
// cache_fsm
//
// Sequencing controller for one cache set array. Processor requests are
// decoded against the set's hit/dirty/tag feedback. A hit is served in the
// same cycle. A miss first streams a dirty victim line out to memory one word
// at a time, and then refills the line from memory one word at a time. The
// processor is stalled until the access hits.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   read_en_i       processor read request
//   write_en_i      processor write request (wins if both enables are set)
//   addr_i          processor byte address, held stable while stall_o=1
//   hit_i           set reports a tag match on a valid line
//   dirty_i         victim line in the set is dirty
//   tag_i           victim line tag
//   mem_ready_i     memory accepted/returned the current word this cycle
//   control_o       {write_en, set_valid, set_dirty, strategy_en, offset_sel}
//   mem_addr_o      memory word address; its word bits also index the set
//   mem_read_en_o   refill read request
//   mem_write_en_o  write-back request (data comes from the set read port)
//   stall_o         processor must hold its request
// ---------------------------------------------------------------------------

`ifndef CACHE_T
`define CACHE_T 26
`endif
`ifndef CACHE_S
`define CACHE_S 2
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_fsm #(
  parameter int TAG_WIDTH    = `CACHE_T,
  parameter int SET_WIDTH    = `CACHE_S,
  parameter int OFFSET_WIDTH = `CACHE_B
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 read_en_i,
  input  logic                 write_en_i,
  input  logic [31:0]          addr_i,
  input  logic                 hit_i,
  input  logic                 dirty_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 mem_ready_i,
  output logic [4:0]           control_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_read_en_o,
  output logic                 mem_write_en_o,
  output logic                 stall_o
);

  // Word counter width: one count per 32-bit word of the line.
  localparam int CNT_WIDTH = OFFSET_WIDTH - 2;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WRITE_BACK = 2'd1;
  localparam logic [1:0] ALLOCATE   = 2'd2;

  // Control vector encodings presented to the set.
  localparam logic [4:0] CTRL_NONE      = 5'b00000;
  localparam logic [4:0] CTRL_READ_HIT  = 5'b00011;
  localparam logic [4:0] CTRL_WRITE_HIT = 5'b11111;
  localparam logic [4:0] CTRL_REFILL    = 5'b11000;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;

  logic                          req;
  logic [SET_WIDTH-1:0]          set_index;
  logic [31-OFFSET_WIDTH:0]      line_base;
  logic                          unused_addr_bits;

  assign req       = read_en_i | write_en_i;
  assign set_index = addr_i[SET_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign line_base = addr_i[31:OFFSET_WIDTH];

  // The byte offset within a word never reaches memory or the FSM; word
  // selection comes from cnt during a miss and from the set on a hit.
  assign unused_addr_bits = ^addr_i[OFFSET_WIDTH-1:0];

  // State and word counter registers; reset aborts any miss in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic and all outputs. Outputs are purely combinational so a
  // hit needs no stall cycle and a memory handshake can complete in the
  // same cycle the request appears.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    control_o      = CTRL_NONE;
    mem_addr_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    stall_o        = 1'b0;

    case (state)
      IDLE: begin
        if (req) begin
          if (hit_i) begin
            control_o = write_en_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
          end else begin
            stall_o    = 1'b1;
            cnt_next   = '0;
            state_next = dirty_i ? WRITE_BACK : ALLOCATE;
          end
        end
      end

      // The victim address is rebuilt from the stored tag; offset_sel=0
      // lets mem_addr_o pick the word the set presents on its read port.
      WRITE_BACK: begin
        stall_o        = 1'b1;
        mem_write_en_o = 1'b1;
        mem_addr_o     = {tag_i, set_index, cnt, 2'b00};
        if (mem_ready_i) begin
          if (cnt == CNT_LAST) begin
            cnt_next   = '0;
            state_next = ALLOCATE;
          end else begin
            cnt_next = cnt + CNT_ONE;
          end
        end
      end

      // Each returned word is written straight into the victim line. Valid
      // goes up with the first word, so a reset mid-refill leaves a line
      // that reads as valid; the processor simply retries.
      ALLOCATE: begin
        stall_o       = 1'b1;
        mem_read_en_o = 1'b1;
        mem_addr_o    = {line_base, cnt, 2'b00};
        if (mem_ready_i) begin
          control_o = CTRL_REFILL;
          cnt_next  = cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_fsm
//
// Bench for cache_fsm with W=4 words per line and four sets. The bench plays
// the role of a direct-mapped set array (tag/valid/dirty per set) and of a
// memory with random ready. For every request it predicts, from the set
// contents, the full list of memory beats and the final hit, and queues
// them. A monitor on the falling edge pops and compares whenever the DUT
// completes a memory beat or serves a hit.
// ---------------------------------------------------------------------------

module tb_cache_fsm;

  localparam int TW = 26;
  localparam int SW = 2;
  localparam int OW = 4;
  localparam int WORDS = 4;

  localparam logic [1:0] K_WB  = 2'd0;
  localparam logic [1:0] K_RF  = 2'd1;
  localparam logic [1:0] K_HIT = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [4:0]  ctrl;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          read_en_i = 1'b0;
  logic          write_en_i = 1'b0;
  logic [31:0]   addr_i = '0;
  logic          hit_i;
  logic          dirty_i;
  logic [TW-1:0] tag_i;
  logic          mem_ready_i = 1'b0;
  logic [4:0]    control_o;
  logic [31:0]   mem_addr_o;
  logic          mem_read_en_o;
  logic          mem_write_en_o;
  logic          stall_o;

  int checks = 0;
  int failures = 0;

  beat_t expQ[$];

  // Set-array model state and its bench-side controls.
  logic          setValid [4];
  logic          setDirty [4];
  logic [TW-1:0] setTag   [4];
  logic          clearSets = 1'b1;
  logic          presetEn = 1'b0;
  logic [1:0]    presetSet = '0;
  logic [TW-1:0] presetTag = '0;
  logic          presetValid = 1'b0;
  logic          presetDirty = 1'b0;

  bit alwaysReady = 1'b1;
  bit monEnable = 1'b0;
  bit prevWait = 1'b0;
  logic [31:0] prevAddr = '0;

  cache_fsm #(
    .TAG_WIDTH(TW),
    .SET_WIDTH(SW),
    .OFFSET_WIDTH(OW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .read_en_i(read_en_i),
    .write_en_i(write_en_i),
    .addr_i(addr_i),
    .hit_i(hit_i),
    .dirty_i(dirty_i),
    .tag_i(tag_i),
    .mem_ready_i(mem_ready_i),
    .control_o(control_o),
    .mem_addr_o(mem_addr_o),
    .mem_read_en_o(mem_read_en_o),
    .mem_write_en_o(mem_write_en_o),
    .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  // Set feedback follows the model contents for the addressed set.
  always_comb begin
    hit_i   = setValid[addr_i[5:4]] && (setTag[addr_i[5:4]] == addr_i[31:6]);
    dirty_i = setValid[addr_i[5:4]] && setDirty[addr_i[5:4]];
    tag_i   = setTag[addr_i[5:4]];
  end

  // The set array: written whenever the controller raises write_en, taking
  // valid/dirty from the control vector and the tag from the request.
  always @(posedge clk_i) begin
    if (clearSets) begin
      for (int i = 0; i < 4; i++) begin
        setValid[i] <= 1'b0;
        setDirty[i] <= 1'b0;
        setTag[i]   <= '0;
      end
    end else if (presetEn) begin
      setValid[presetSet] <= presetValid;
      setDirty[presetSet] <= presetDirty;
      setTag[presetSet]   <= presetTag;
    end else if (!rst_i && control_o[4]) begin
      setValid[addr_i[5:4]] <= control_o[3];
      setDirty[addr_i[5:4]] <= control_o[2];
      setTag[addr_i[5:4]]   <= addr_i[31:6];
    end
  end

  // Memory readiness: always ready or roughly two thirds of cycles.
  always @(posedge clk_i) begin
    #1;
    mem_ready_i = alwaysReady ? 1'b1 : ($urandom_range(0, 99) < 65);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic popExpected(output beat_t b, output bit ok);
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL queue_empty: DUT produced an unexpected response at %0t", $time);
      ok = 1'b0;
      b = '0;
    end else begin
      b = expQ.pop_front();
      ok = 1'b1;
    end
  endtask

  // Monitor: compares every completed memory beat and every served hit
  // against the queued prediction, and checks quiet/hold behaviour.
  always @(negedge clk_i) begin
    beat_t b;
    bit ok;
    logic req;
    req = read_en_i | write_en_i;
    if (!monEnable || rst_i) begin
      prevWait = 1'b0;
    end else if (mem_read_en_o || mem_write_en_o) begin
      checkOutput("single_enable", 32'(mem_read_en_o & mem_write_en_o), 32'd0);
      checkOutput("miss_stall", 32'(stall_o), 32'd1);
      if (prevWait) checkOutput("wait_addr_hold", mem_addr_o, prevAddr);
      if (mem_ready_i) begin
        popExpected(b, ok);
        if (ok) begin
          checkOutput("beat_kind", 32'(mem_write_en_o ? K_WB : K_RF), 32'(b.kind));
          checkOutput("beat_addr", mem_addr_o, b.addr);
          checkOutput("beat_ctrl", 32'(control_o), 32'(b.ctrl));
        end
      end else begin
        checkOutput("wait_no_set_write", 32'(control_o), 32'd0);
      end
      prevWait = !mem_ready_i;
      prevAddr = mem_addr_o;
    end else begin
      prevWait = 1'b0;
      if (!req) begin
        checkOutput("idle_ctrl", 32'(control_o), 32'd0);
        checkOutput("idle_addr", mem_addr_o, 32'd0);
        checkOutput("idle_stall", 32'(stall_o), 32'd0);
      end else if (!stall_o) begin
        popExpected(b, ok);
        if (ok) begin
          checkOutput("hit_kind", 32'(K_HIT), 32'(b.kind));
          checkOutput("hit_ctrl", 32'(control_o), 32'(b.ctrl));
          checkOutput("hit_addr", mem_addr_o, 32'd0);
        end
      end else begin
        checkOutput("miss_ctrl", 32'(control_o), 32'd0);
        checkOutput("miss_addr", mem_addr_o, 32'd0);
      end
    end
  end

  task automatic presetLine(input logic [1:0] s, input logic [TW-1:0] t, input logic v, input logic d);
    @(posedge clk_i);
    #2;
    presetSet = s;
    presetTag = t;
    presetValid = v;
    presetDirty = d;
    presetEn = 1'b1;
    @(posedge clk_i);
    #2;
    presetEn = 1'b0;
  endtask

  // Issue one request, queue its predicted beats, and hold it until served.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input bit fastMem);
    logic [1:0]    s;
    logic [TW-1:0] oldTag;
    bit            hit;
    bit            dirty;
    int            stallCount;
    int            expStall;
    bit            served;
    @(posedge clk_i);
    #2;
    s = a[5:4];
    hit = setValid[s] && (setTag[s] == a[31:6]);
    dirty = setValid[s] && setDirty[s];
    oldTag = setTag[s];
    if (!hit) begin
      if (dirty) begin
        for (int i = 0; i < WORDS; i++) expQ.push_back('{K_WB, {oldTag, s, 2'(i), 2'b00}, 5'b00000});
      end
      for (int i = 0; i < WORDS; i++) expQ.push_back('{K_RF, {a[31:4], 2'(i), 2'b00}, 5'b11000});
    end
    expQ.push_back('{K_HIT, 32'd0, wr ? 5'b11111 : 5'b00011});
    expStall = hit ? 0 : (1 + WORDS + (dirty ? WORDS : 0));
    alwaysReady = fastMem;
    addr_i = a;
    read_en_i = rd;
    write_en_i = wr;
    stallCount = 0;
    served = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        served = 1'b1;
        break;
      end
      stallCount++;
    end
    if (!served) checkOutput("request_timeout", 32'd0, 32'd1);
    else if (fastMem) checkOutput("stall_cycles", 32'(stallCount), 32'(expStall));
    @(posedge clk_i);
    #2;
    read_en_i = 1'b0;
    write_en_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [TW-1:0] t;
    logic [1:0] s;
    logic [1:0] w;
    int kindSel;
    bit found;

    repeat (3) @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    clearSets = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_ctrl", 32'(control_o), 32'd0);
    checkOutput("reset_addr", mem_addr_o, 32'd0);
    checkOutput("reset_mem_en", 32'({mem_read_en_o, mem_write_en_o}), 32'd0);
    checkOutput("reset_stall", 32'(stall_o), 32'd0);
    monEnable = 1'b1;

    $display("[TB] directed: read hit, write hit, clean miss, dirty miss");
    presetLine(2'd0, 26'h40, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_1008, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_1008, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, 1'b1);
    presetLine(2'd1, 26'hABC, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h0000_0010, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, 1'b0);

    $display("[TB] random requests with random memory waits");
    for (int n = 0; n < 80; n++) begin
      t = 26'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      w = 2'($urandom_range(0, 3));
      kindSel = $urandom_range(0, 2);
      applyStimulus(kindSel != 1, kindSel != 0, {t, s, w, 2'b00}, $urandom_range(0, 3) == 0);
    end

    $display("[TB] reset during refill");
    monEnable = 1'b0;
    presetLine(2'd2, 26'h7, 1'b1, 1'b0);
    @(posedge clk_i);
    #2;
    alwaysReady = 1'b1;
    addr_i = {26'h55, 2'b10, 4'h0};
    read_en_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      if (mem_read_en_o && mem_addr_o == {26'h55, 2'b10, 2'd2, 2'b00}) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("reach_alloc_word2", 32'(found), 32'd1);
    rst_i = 1'b1;
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("abort_read_en", 32'(mem_read_en_o), 32'd0);
    checkOutput("abort_write_en", 32'(mem_write_en_o), 32'd0);
    checkOutput("abort_stall_partial_valid", 32'(stall_o), 32'd0);
    checkOutput("abort_ctrl_hit", 32'(control_o), 32'b00011);
    @(posedge clk_i);
    #2;
    read_en_i = 1'b0;
    expQ.delete();
    repeat (2) @(negedge clk_i);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
